// File: rtl/call_stack.sv
// Pointer-based return-address stack of {pc, flags} entries with depth, full/empty and sticky error status.
// Push/pop take effect at the clock edge and the new top appears right after it; a full push is dropped or overwrites the oldest entry.
module call_stack #(
  parameter int TAM    = 16,
  parameter int NFLAGS = 3,
  parameter int NSTACK = 8,
  parameter int WRAP   = 0,
  parameter int DW     = $clog2(NSTACK) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [TAM-1:0]    pcIn,
  input  logic [NFLAGS-1:0] flagsIn,
  input  logic              clrErr,
  output logic [TAM-1:0]    pcOut,
  output logic [NFLAGS-1:0] flagsOut,
  output logic              empty,
  output logic              full,
  output logic [DW-1:0]     depth,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = $clog2(NSTACK);
  localparam int EW = TAM + NFLAGS;

  typedef logic [EW-1:0] entry_t;

  entry_t          mem_q [NSTACK];
  entry_t          mem_d [NSTACK];
  logic [AW-1:0]   top_q, top_d;
  logic [DW-1:0]   count_q, count_d;
  logic            overflow_q, overflow_d;
  logic            underflow_q, underflow_d;
  logic            is_empty, is_full;
  logic            ovf_evt, unf_evt;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == DW'(NSTACK));

  always_comb begin
    top_d   = top_q;
    count_d = count_q;
    mem_d   = mem_q;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    if (push && pop && !is_empty) begin
      mem_d[top_q] = {pcIn, flagsIn};
    end else if (push) begin
      // pop can only be set here when the stack is empty
      unf_evt = pop;
      if (!is_full) begin
        top_d        = is_empty ? top_q : top_q + 1'b1;
        mem_d[top_d] = {pcIn, flagsIn};
        count_d      = count_q + 1'b1;
      end else begin
        ovf_evt = 1'b1;
        if (WRAP != 0) begin
          top_d        = top_q + 1'b1;
          mem_d[top_d] = {pcIn, flagsIn};
        end
      end
    end else if (pop) begin
      if (is_empty) begin
        unf_evt = 1'b1;
      end else begin
        count_d = count_q - 1'b1;
        // the last entry keeps its slot so the next push from empty reuses it
        if (count_q != DW'(1)) top_d = top_q - 1'b1;
      end
    end
    overflow_d  = ovf_evt | (overflow_q & ~clrErr);
    underflow_d = unf_evt | (underflow_q & ~clrErr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_q       <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      for (int i = 0; i < NSTACK; i++) mem_q[i] <= '0;
    end else begin
      top_q       <= top_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      mem_q       <= mem_d;
    end
  end

  assign {pcOut, flagsOut} = is_empty ? '0 : mem_q[top_q];
  assign empty     = is_empty;
  assign full      = is_full;
  assign depth     = count_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_call_stack.sv
// Bench for call_stack: a reject-mode and a wrap-mode instance, both 4 deep, driven from a vector table.
module tb_call_stack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        push_i [2];
  logic        pop_i  [2];
  logic        clr_i  [2];
  logic [15:0] pc_i   [2];
  logic [2:0]  fl_i   [2];
  logic [15:0] pc_o   [2];
  logic [2:0]  fl_o   [2];
  logic        empty_o[2];
  logic        full_o [2];
  logic [2:0]  dep_o  [2];
  logic        ovf_o  [2];
  logic        unf_o  [2];

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          d;
    bit          push, pop, clr;
    logic [15:0] pc;
    logic [2:0]  fl;
    logic [15:0] e_pc;
    logic [2:0]  e_fl;
    int          e_dep;
    bit          e_ovf, e_unf;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  always #5 clk = ~clk;

  call_stack #(.TAM(16), .NFLAGS(3), .NSTACK(4), .WRAP(0)) u_nowrap (
    .clk(clk), .rst(rst), .push(push_i[0]), .pop(pop_i[0]), .pcIn(pc_i[0]),
    .flagsIn(fl_i[0]), .clrErr(clr_i[0]), .pcOut(pc_o[0]), .flagsOut(fl_o[0]),
    .empty(empty_o[0]), .full(full_o[0]), .depth(dep_o[0]),
    .overflow(ovf_o[0]), .underflow(unf_o[0])
  );

  call_stack #(.TAM(16), .NFLAGS(3), .NSTACK(4), .WRAP(1)) u_wrap (
    .clk(clk), .rst(rst), .push(push_i[1]), .pop(pop_i[1]), .pcIn(pc_i[1]),
    .flagsIn(fl_i[1]), .clrErr(clr_i[1]), .pcOut(pc_o[1]), .flagsOut(fl_o[1]),
    .empty(empty_o[1]), .full(full_o[1]), .depth(dep_o[1]),
    .overflow(ovf_o[1]), .underflow(unf_o[1])
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_state(int d, string tag, logic [15:0] epc, logic [2:0] efl,
                             int edep, bit eovf, bit eunf);
    chk({tag, ".pc"},    32'(pc_o[d]),    32'(epc));
    chk({tag, ".flags"}, 32'(fl_o[d]),    32'(efl));
    chk({tag, ".depth"}, 32'(dep_o[d]),   32'(edep));
    chk({tag, ".empty"}, 32'(empty_o[d]), 32'(edep == 0));
    chk({tag, ".full"},  32'(full_o[d]),  32'(edep == 4));
    chk({tag, ".ovf"},   32'(ovf_o[d]),   32'(eovf));
    chk({tag, ".unf"},   32'(unf_o[d]),   32'(eunf));
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      push_i[k] = 1'b0; pop_i[k] = 1'b0; clr_i[k] = 1'b0;
      pc_i[k] = '0; fl_i[k] = '0;
    end
  endtask

  task automatic add(int d, bit pu, bit po, bit cl, logic [15:0] pc, logic [2:0] fl,
                     logic [15:0] epc, logic [2:0] efl, int edep, bit eo, bit eu);
    vec_t v;
    v.d = d; v.push = pu; v.pop = po; v.clr = cl; v.pc = pc; v.fl = fl;
    v.e_pc = epc; v.e_fl = efl; v.e_dep = edep; v.e_ovf = eo; v.e_unf = eu;
    vecs.push_back(v);
  endtask

  task automatic apply(vec_t v, string tag);
    vec_t e;
    idle_inputs();
    push_i[v.d] = v.push; pop_i[v.d] = v.pop; clr_i[v.d] = v.clr;
    pc_i[v.d] = v.pc; fl_i[v.d] = v.fl;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_state(e.d, tag, e.e_pc, e.e_fl, e.e_dep, e.e_ovf, e.e_unf);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    idle_inputs();

    // basic push/pop on the reject-mode stack
    add(0, 1, 0, 0, 16'h1001, 3'd1, 16'h1001, 3'd1, 1, 0, 0);
    add(0, 1, 0, 0, 16'h1002, 3'd2, 16'h1002, 3'd2, 2, 0, 0);
    add(0, 1, 0, 0, 16'h1003, 3'd3, 16'h1003, 3'd3, 3, 0, 0);
    add(0, 0, 1, 0, 16'h0,    3'd0, 16'h1002, 3'd2, 2, 0, 0);
    add(0, 0, 1, 0, 16'h0,    3'd0, 16'h1001, 3'd1, 1, 0, 0);
    add(0, 0, 1, 0, 16'h0,    3'd0, 16'h0,    3'd0, 0, 0, 0);
    // fill and overflow in reject mode
    for (int i = 0; i < 4; i++)
      add(0, 1, 0, 0, 16'(16'hA0 + i), 3'(i), 16'(16'hA0 + i), 3'(i), i + 1, 0, 0);
    add(0, 1, 0, 0, 16'hA4, 3'd4, 16'hA3, 3'd3, 4, 1, 0);
    for (int i = 2; i >= 0; i--)
      add(0, 0, 1, 0, 16'h0, 3'd0, 16'(16'hA0 + i), 3'(i), i + 1, 1, 0);
    add(0, 0, 1, 0, 16'h0,    3'd0, 16'h0,    3'd0, 0, 1, 0);
    // underflow, push+pop on empty, clear
    add(0, 0, 1, 0, 16'h0,    3'd0, 16'h0,    3'd0, 0, 1, 1);
    add(0, 1, 1, 0, 16'h0055, 3'd5, 16'h0055, 3'd5, 1, 1, 1);
    add(0, 0, 0, 1, 16'h0,    3'd0, 16'h0055, 3'd5, 1, 0, 0);
    // replace-top
    add(0, 1, 0, 0, 16'h0200, 3'd2, 16'h0200, 3'd2, 2, 0, 0);
    add(0, 1, 1, 0, 16'h0300, 3'd7, 16'h0300, 3'd7, 2, 0, 0);
    add(0, 0, 1, 0, 16'h0,    3'd0, 16'h0055, 3'd5, 1, 0, 0);
    add(0, 0, 1, 0, 16'h0,    3'd0, 16'h0,    3'd0, 0, 0, 0);
    // overflow set wins over concurrent clear; replace while full
    for (int i = 0; i < 4; i++)
      add(0, 1, 0, 0, 16'(16'hC0 + i), 3'(i), 16'(16'hC0 + i), 3'(i), i + 1, 0, 0);
    add(0, 1, 0, 1, 16'hC4, 3'd4, 16'hC3, 3'd3, 4, 1, 0);
    add(0, 0, 0, 1, 16'h0,  3'd0, 16'hC3, 3'd3, 4, 0, 0);
    add(0, 1, 1, 0, 16'hD0, 3'd6, 16'hD0, 3'd6, 4, 0, 0);
    add(0, 0, 1, 0, 16'h0,  3'd0, 16'hC2, 3'd2, 3, 0, 0);
    // wrap mode: oldest entries overwritten
    for (int i = 0; i < 4; i++)
      add(1, 1, 0, 0, 16'(16'hB0 + i), 3'(i), 16'(16'hB0 + i), 3'(i), i + 1, 0, 0);
    add(1, 1, 0, 0, 16'hB4, 3'd4, 16'hB4, 3'd4, 4, 1, 0);
    add(1, 1, 0, 0, 16'hB5, 3'd5, 16'hB5, 3'd5, 4, 1, 0);
    add(1, 0, 1, 0, 16'h0,  3'd0, 16'hB4, 3'd4, 3, 1, 0);
    add(1, 0, 1, 0, 16'h0,  3'd0, 16'hB3, 3'd3, 2, 1, 0);
    add(1, 0, 1, 0, 16'h0,  3'd0, 16'hB2, 3'd2, 1, 1, 0);
    add(1, 0, 1, 0, 16'h0,  3'd0, 16'h0,  3'd0, 0, 1, 0);

    #3;
    check_state(0, "rst0", 16'h0, 3'd0, 0, 0, 0);
    check_state(1, "rst1", 16'h0, 3'd0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("v%0d", i));

    // asynchronous reset with the reject-mode stack at depth 3
    idle_inputs();
    rst = 1'b1;
    #2;
    check_state(0, "arst0", 16'h0, 3'd0, 0, 0, 0);
    check_state(1, "arst1", 16'h0, 3'd0, 0, 0, 0);
    push_i[0] = 1'b1; pc_i[0] = 16'hEEEE; fl_i[0] = 3'd7;
    @(posedge clk);
    #1;
    check_state(0, "rsthold", 16'h0, 3'd0, 0, 0, 0);
    rst = 1'b0;
    idle_inputs();

    v.d = 0; v.push = 1; v.pop = 0; v.clr = 0; v.pc = 16'h00E1; v.fl = 3'd1;
    v.e_pc = 16'h00E1; v.e_fl = 3'd1; v.e_dep = 1; v.e_ovf = 0; v.e_unf = 0;
    apply(v, "post_rst");
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
